// File: rtl/mux_serializador_if.sv
// Bus between a parallel data source and mux_serializador.
// The master drives data/selection/mode/start and the slave returns the serial bit and status.
interface mux_serializador_if #(
  parameter int N_DATA = 4
) ();
  localparam int SEL_W = $clog2(N_DATA);

  logic [N_DATA-1:0] i_data;
  logic [SEL_W-1:0]  i_selector;
  logic [1:0]        i_mode;
  logic              i_start;
  logic              o_q;
  logic [SEL_W-1:0]  o_sel;
  logic              o_busy;
  logic              o_done;

  modport master (
    output i_data, i_selector, i_mode, i_start,
    input  o_q, o_sel, o_busy, o_done
  );

  modport slave (
    input  i_data, i_selector, i_mode, i_start,
    output o_q, o_sel, o_busy, o_done
  );
endinterface

// File: rtl/mux_serializador.sv
// Registered bit selector with manual, auto-scan and start-triggered serial modes.
// The serial transfer FSM is active only in mode 10; any other mode parks it in IDLE.
//
//   state    | meaning
//   ST_IDLE  | no transfer; o_q holds, waiting for i_start in serial mode
//   ST_SHIFT | one bit of the captured word is driven per edge (o_busy)
//   ST_DONE  | single cycle after the last bit is driven (o_done)
module mux_serializador #(
  parameter int N_DATA    = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic              i_clk,
  input logic              i_rst,
  mux_serializador_if.slave bus
);
  localparam int SEL_W = $clog2(N_DATA);

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_SERIAL = 2'b10;

  localparam logic [SEL_W-1:0] LAST_BIT = SEL_W'(N_DATA - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state;
  logic              q_r;
  logic [SEL_W-1:0]  sel_r;
  logic [SEL_W-1:0]  scan_cnt;
  logic [SEL_W-1:0]  bit_cnt;
  logic [N_DATA-1:0] shreg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      q_r      <= 1'b0;
      sel_r    <= '0;
      scan_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      // The scan index restarts whenever scan mode is left, so scanning always begins at input 0.
      if (bus.i_mode == MODE_SCAN) begin
        scan_cnt <= scan_cnt + 1'b1;
      end else begin
        scan_cnt <= '0;
      end

      case (bus.i_mode)
        MODE_MANUAL: begin
          q_r   <= bus.i_data[bus.i_selector];
          sel_r <= bus.i_selector;
          state <= ST_IDLE;
        end
        MODE_SCAN: begin
          q_r   <= bus.i_data[scan_cnt];
          sel_r <= scan_cnt;
          state <= ST_IDLE;
        end
        MODE_SERIAL: begin
          case (state)
            ST_IDLE: begin
              if (bus.i_start) begin
                shreg   <= bus.i_data;
                bit_cnt <= '0;
                state   <= ST_SHIFT;
              end
            end
            ST_SHIFT: begin
              if (MSB_FIRST) begin
                q_r   <= shreg[N_DATA-1];
                shreg <= {shreg[N_DATA-2:0], 1'b0};
              end else begin
                q_r   <= shreg[0];
                shreg <= {1'b0, shreg[N_DATA-1:1]};
              end
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                state <= ST_DONE;
              end
            end
            ST_DONE: begin
              state <= ST_IDLE;
            end
            default: begin
              state <= ST_IDLE;
            end
          endcase
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_q    = q_r;
  assign bus.o_sel  = sel_r;
  assign bus.o_busy = (state == ST_SHIFT);
  assign bus.o_done = (state == ST_DONE);
endmodule
